// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES datapath definitions: state geometry, byte/column/state types, and
// the ShiftRows byte-index helpers used by the column-serial stages.
//
// Byte order: state byte k = 4*c + r (column c, row r) lives at bits
// [8k:8k+7] of an ascending [0:127] bus, so byte 0 is the MSB-first byte at
// bit 0. Columns follow the same rule at 32-bit granularity.
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int BYTE_SIZE = 8;
  localparam int NUM_COLS  = 4;
  localparam int NUM_ROWS  = 4;
  localparam int STATE_W   = 128;
  localparam int COL_W     = 32;

  typedef logic [0:BYTE_SIZE-1] byte_t;
  typedef logic [0:COL_W-1]     col_t;
  typedef logic [0:STATE_W-1]   state_t;

  // Source byte index for InvShiftRows: out[r][c] = in[r][(c - r) mod 4].
  function automatic int inv_shift_index(input int k);
    int c;
    int r;
    c = k / NUM_ROWS;
    r = k % NUM_ROWS;
    return NUM_ROWS * ((c - r + NUM_COLS) % NUM_COLS) + r;
  endfunction

  // Source byte index for forward ShiftRows: out[r][c] = in[r][(c + r) mod 4].
  function automatic int shift_index(input int k);
    int c;
    int r;
    c = k / NUM_ROWS;
    r = k % NUM_ROWS;
    return NUM_ROWS * ((c + r) % NUM_COLS) + r;
  endfunction

endpackage

// File: rtl/inv_shift_rows.sv
// -----------------------------------------------------------------------------
// inv_shift_rows
// Purely combinational 128-bit InvShiftRows byte permutation (wiring only).
//
// Optional build macro: FWD_SHIFT_ROWS_EN adds a fwd select that switches the
// same network to the forward ShiftRows mapping.
//
// Ports:
//   state_in   input  [0:127]  state before permutation
//   fwd        input  1        (FWD_SHIFT_ROWS_EN only) 1 = forward mapping
//   state_out  output [0:127]  permuted state
// -----------------------------------------------------------------------------
module inv_shift_rows
  import aes_pkg::*;
(
  input  state_t state_in,
`ifdef FWD_SHIFT_ROWS_EN
  input  logic   fwd,
`endif
  output state_t state_out
);

  localparam int NUM_BYTES = STATE_W / BYTE_SIZE;

  for (genvar k = 0; k < NUM_BYTES; k++) begin : g_byte
    localparam int INV_SRC = inv_shift_index(k);
`ifdef FWD_SHIFT_ROWS_EN
    localparam int FWD_SRC = shift_index(k);
    assign state_out[k*BYTE_SIZE +: BYTE_SIZE] =
      fwd ? state_in[FWD_SRC*BYTE_SIZE +: BYTE_SIZE]
          : state_in[INV_SRC*BYTE_SIZE +: BYTE_SIZE];
`else
    assign state_out[k*BYTE_SIZE +: BYTE_SIZE] = state_in[INV_SRC*BYTE_SIZE +: BYTE_SIZE];
`endif
  end

endmodule

// File: rtl/inv_shift_rows_stream.sv
// -----------------------------------------------------------------------------
// inv_shift_rows_stream
// Column-serial InvShiftRows stage for the iterative AES decrypt round.
// A 128-bit state arrives one 32-bit column per cycle, is captured in one of
// two ping-pong banks, and is emitted inverse-permuted, column by column.
// With both banks cycling the stage sustains one column per cycle.
//
// Optional build macro: FWD_SHIFT_ROWS_EN adds a fwd input, sampled with
// column 0 of each state and kept with its bank, selecting forward ShiftRows
// so the same block serves encrypt rounds. Timing is identical in both builds.
//
// Ports:
//   clk      input         rising-edge clock
//   rst_n    input         asynchronous active-low reset
//   flush    input         synchronous clear of buffered and partial states
//   s_valid  input         input column valid
//   s_ready  output        stage can accept a column
//   s_data   input  [0:31] input column; row r at bits [8r:8r+7]
//   fwd      input         (FWD_SHIFT_ROWS_EN only) forward mapping select
//   m_valid  output        output column valid
//   m_ready  input         downstream accepts a column
//   m_data   output [0:31] output column, same byte order as s_data
//   m_last   output        high with output column 3
// -----------------------------------------------------------------------------
module inv_shift_rows_stream #(
  parameter int BYTE_SIZE = 8,  // only 8 is legal
  parameter int NUM_COLS  = 4   // only 4 is legal
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [0:NUM_COLS*BYTE_SIZE-1]   s_data,
`ifdef FWD_SHIFT_ROWS_EN
  input  logic                            fwd,
`endif
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [0:NUM_COLS*BYTE_SIZE-1]   m_data,
  output logic                            m_last
);

  localparam int COL_W = NUM_COLS * BYTE_SIZE;

  aes_pkg::state_t bank [2];
  logic [1:0]      full;
  logic            wr_bank;
  logic [1:0]      wr_col;
  logic            rd_bank;
  logic [1:0]      rd_col;
`ifdef FWD_SHIFT_ROWS_EN
  logic [1:0]      fwd_bank;
`endif

  logic            accept;
  logic            beat;
  aes_pkg::state_t rd_state;
  aes_pkg::state_t perm_state;

  assign s_ready = !full[wr_bank];
  assign m_valid = full[rd_bank];
  assign m_last  = m_valid & (rd_col == 2'd3);
  assign accept  = s_valid & s_ready;
  assign beat    = m_valid & m_ready;

  // NOTE: non-blocking assignments throughout so every update in this block
  // sees the pre-edge pointers and flags, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= '0;
      wr_bank <= 1'b0;
      wr_col  <= '0;
      rd_bank <= 1'b0;
      rd_col  <= '0;
      // NOTE: the banks are reset too, so m_data reads 0 (never X) out of reset
      // even though no state has been captured yet.
      bank    <= '{default: '0};
`ifdef FWD_SHIFT_ROWS_EN
      fwd_bank <= '0;
`endif
    end else if (flush) begin
      // Bank data is deliberately left alone; only flags and pointers clear.
      full    <= '0;
      wr_bank <= 1'b0;
      wr_col  <= '0;
      rd_bank <= 1'b0;
      rd_col  <= '0;
    end else begin
      if (accept) begin
        bank[wr_bank][{wr_col, 5'b0} +: COL_W] <= s_data;
        wr_col <= wr_col + 2'd1;
`ifdef FWD_SHIFT_ROWS_EN
        if (wr_col == 2'd0) fwd_bank[wr_bank] <= fwd;
`endif
        if (wr_col == 2'd3) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end
      end
      // A completing fill needs !full[wr_bank] and a completing drain needs
      // full[rd_bank], so the two flag writes always target different banks.
      if (beat) begin
        rd_col <= rd_col + 2'd1;
        if (rd_col == 2'd3) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end
      end
    end
  end

  // Permute the whole selected bank, then pick the column being presented.
  assign rd_state = bank[rd_bank];

  inv_shift_rows u_inv_shift_rows (
    .state_in  (rd_state),
`ifdef FWD_SHIFT_ROWS_EN
    .fwd       (fwd_bank[rd_bank]),
`endif
    .state_out (perm_state)
  );

  assign m_data = perm_state[{rd_col, 5'b0} +: COL_W];

endmodule
